// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the serial nibble adder sequencer.
package serial_add_pkg;

   // Sequencer states: waiting for start, stepping nibbles, result pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   // Width of one slice handled by the shared adder
   localparam int NIB_W = 4;

   // Default number of nibbles per operand
   localparam int DEF_WORDS = 4;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand bus between the front end and the sequencer.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WORDS = DEF_WORDS
);

   logic                     start;
   logic                     sub;
   logic [NIB_W*WORDS-1:0]   a;
   logic [NIB_W*WORDS-1:0]   b;
   logic                     busy;
   logic                     done;
   logic [NIB_W*WORDS-1:0]   result;
   logic                     cout;
   logic                     overflow;

   // Front end issues requests and watches the result
   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, overflow
   );

   // Sequencer accepts requests and reports the result
   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, overflow
   );

endinterface

// File: rtl/serial_add_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder made of full-adder cells.
module nibble_adder
   import serial_add_pkg::*;
(
   output logic [NIB_W-1:0] S,
   output logic             cout,
   input  logic [NIB_W-1:0] A,
   input  logic [NIB_W-1:0] B,
   input  logic             cin
);

   logic [NIB_W:0] w_carryChain;

   assign w_carryChain[0] = cin;

   // One full-adder cell per bit, carry rippling from bit 0 upward
   for (genvar i = 0; i < NIB_W; i++) begin : g_fullAdder
      assign S[i]                = A[i] ^ B[i] ^ w_carryChain[i];
      assign w_carryChain[i + 1] = (A[i] & B[i]) | (w_carryChain[i] & (A[i] ^ B[i]));
   end

   assign cout = w_carryChain[NIB_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-nibble add/subtract sequencer sharing one 4-bit adder over WORDS cycles.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WORDS = DEF_WORDS
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_add_ctrl_if.slave      bus
);

   localparam int OP_W  = NIB_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   stateT               r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [OP_W-1:0]     r_opA;
   logic [OP_W-1:0]     r_opB;
   logic [OP_W-1:0]     r_result;
   logic                r_cout;
   logic                r_overflow;
   logic                r_busy;
   logic                r_done;

   logic [NIB_W-1:0]    w_sum;
   logic                w_carryOut;
   logic                w_overflow;

   // Operands shift right one nibble per RUN cycle, so the adder always sees the low nibble
   nibble_adder u_adder (
      .S    (w_sum),
      .cout (w_carryOut),
      .A    (r_opA[NIB_W-1:0]),
      .B    (r_opB[NIB_W-1:0]),
      .cin  (r_carry)
   );

   // On the last nibble the low bit 3 of each shifted operand is the original MSB
   assign w_overflow = (r_opA[NIB_W-1] == r_opB[NIB_W-1]) && (w_sum[NIB_W-1] != r_opA[NIB_W-1]);

   // Sequencer FSM and datapath: latch operands, step nibbles, then pulse done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_carry    <= 1'b0;
         r_opA      <= '0;
         r_opB      <= '0;
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_opA      <= bus.a;
                  r_opB      <= bus.sub ? ~bus.b : bus.b;
                  r_carry    <= bus.sub;
                  r_idx      <= '0;
                  r_result   <= '0;
                  r_cout     <= 1'b0;
                  r_overflow <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_result[int'(r_idx)*NIB_W +: NIB_W] <= w_sum;
               r_carry <= w_carryOut;
               r_opA   <= r_opA >> NIB_W;
               r_opB   <= r_opB >> NIB_W;
               if (r_idx == LAST_IDX) begin
                  r_cout     <= w_carryOut;
                  r_overflow <= w_overflow;
                  r_done     <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.result   = r_result;
   assign bus.cout     = r_cout;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for the serial add/subtract sequencer (WORDS=4).
module tb_serial_add_ctrl;

   typedef struct {
      logic [15:0] result;
      logic        cout;
      logic        ovf;
   } expT;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   expT  scoreboard[$];

   serial_add_ctrl_if #(.WORDS(4)) bus ();

   serial_add_ctrl #(.WORDS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model working on whole words rather than nibbles
   function automatic expT model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      expT         e;
      logic [15:0] bb;
      logic [16:0] full;
      bb       = sub ? ~b : b;
      full     = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
      e.result = full[15:0];
      e.cout   = full[16];
      e.ovf    = (a[15] == bb[15]) && (full[15] != a[15]);
      return e;
   endfunction

   // One comparison with immediate assertion
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request right after a falling edge, expect busy on the next one
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub);
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.start = 1'b1;
      scoreboard.push_back(model(a, b, sub));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.sub   = ~sub;
      check("busyAfterStart", 32'(bus.busy), 32'd1);
   endtask

   // Wait for done within a bound, check latency and pop the scoreboard
   task automatic checkOutput(input string tag, input int elapsed);
      int  cycles;
      expT e;
      cycles = elapsed;
      while (!bus.done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_doneSeen"}, 32'(bus.done), 32'd1);
      check({tag, "_latency"}, 32'(cycles), 32'd5);
      if (scoreboard.size() == 0) begin
         check({tag, "_scoreboardEmpty"}, 32'd0, 32'd1);
      end else begin
         e = scoreboard.pop_front();
         check({tag, "_result"}, 32'(bus.result), 32'(e.result));
         check({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
         check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset for ten cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idleBusy", 32'(bus.busy), 32'd0);
         check("idleDone", 32'(bus.done), 32'd0);
         check("idleResult", 32'(bus.result), 32'd0);
      end
      check("idleCout", 32'(bus.cout), 32'd0);
      check("idleOverflow", 32'(bus.overflow), 32'd0);

      // Plain additions, wrap-around and signed overflow
      applyStimulus(16'h1234, 16'h0FFF, 1'b0);
      checkOutput("add1234", 1);
      check("add1234Literal", 32'(bus.result), 32'h2233);
      @(negedge clk);
      check("doneSinglePulse", 32'(bus.done), 32'd0);
      check("busyFallsAfterDone", 32'(bus.busy), 32'd0);

      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      checkOutput("addWrap", 1);
      @(negedge clk);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0);
      checkOutput("addOvf", 1);
      check("addOvfLiteral", 32'(bus.overflow), 32'd1);
      @(negedge clk);

      // Subtractions with borrow and signed overflow
      applyStimulus(16'h0005, 16'h0007, 1'b1);
      checkOutput("subBorrow", 1);
      check("subBorrowLiteral", 32'(bus.result), 32'hFFFE);
      @(negedge clk);
      applyStimulus(16'h8000, 16'h0001, 1'b1);
      checkOutput("subOvf", 1);
      @(negedge clk);
      check("resultHeldIdle", 32'(bus.result), 32'h7FFF);

      // Start held high, operand changed mid-run, start ignored in DONE
      bus.a     = 16'h0001;
      bus.b     = 16'h0001;
      bus.sub   = 1'b0;
      bus.start = 1'b1;
      scoreboard.push_back(model(16'h0001, 16'h0001, 1'b0));
      @(negedge clk);
      check("holdBusy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.a = 16'h00FF;
      checkOutput("holdFirst", 2);
      @(negedge clk);
      check("holdNoSecondDone", 32'(bus.done), 32'd0);
      check("holdIdleCycle", 32'(bus.busy), 32'd0);
      scoreboard.push_back(model(16'h00FF, 16'h0001, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      check("holdRestarted", 32'(bus.busy), 32'd1);
      checkOutput("holdSecond", 1);
      @(negedge clk);

      // Reset during RUN discards the partial operation
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      void'(scoreboard.pop_back());
      check("rstBusy", 32'(bus.busy), 32'd0);
      check("rstResult", 32'(bus.result), 32'd0);
      check("rstDone", 32'(bus.done), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rstNoDone", 32'(bus.done), 32'd0);
      end
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      checkOutput("afterRst", 1);
      check("afterRstLiteral", 32'(bus.result), 32'h3333);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
